ps2_scancode_decoder: RTL
=========================

Name: ps2_scancode_decoder

Overview:
- Consumes the byte stream from ps2_transceiver (data_out / rx_done_tick) and turns PS/2 Set-2 scan-code sequences into one-cycle key events.
- Handles the E0 extended prefix, the F0 break prefix, and the 8-byte E1 Pause sequence.
- Tracks modifier state: shift, ctrl and caps lock.
- Flags device-response bytes (FA ack, AA BAT pass, FC BAT fail) separately so the host-command logic can consume them.

Parameters:
- TIMEOUT_CYCLES, 2_000_000, cycles without a new byte after which a partial sequence is abandoned (20 ms at 100 MHz).
- TO_W, 21, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte from ps2_transceiver data_out.
- rx_done_tick  in  1  one-cycle strobe; rx_data is valid in that cycle.
- key_valid  out  1  one-cycle key event strobe.
- key_code  out  8  final scan-code byte of the event (prefixes stripped).
- key_ext  out  1  event was E0-prefixed.
- key_break  out  1  event was a release (F0-prefixed).
- pause_tick  out  1  one-cycle strobe on completion of the Pause sequence.
- ack_tick  out  1  one-cycle strobe on 0xFA received in IDLE.
- bat_tick  out  1  one-cycle strobe on 0xAA received in IDLE.
- err_tick  out  1  one-cycle strobe on 0x00, 0xFF or 0xFC received in IDLE, or on timeout.
- shift_state  out  1  left or right shift held.
- ctrl_state  out  1  left or right ctrl held.
- caps_lock  out  1  caps-lock toggle state.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low. While reset=0, all outputs are 0, the FSM is in IDLE, and all held bits and the timeout counter are cleared.
- Bytes are processed only in cycles with rx_done_tick=1.
- Every tick/strobe output is registered and asserts exactly one cycle, in the clk cycle after the rx_done_tick that completes the event. key_code, key_ext and key_break are held until the next key_valid.
- FSM states: IDLE, EXT, BRK, EXT_BRK, PAUSE.
- IDLE transitions:
  - E0 -> EXT.
  - F0 -> BRK.
  - E1 -> PAUSE, with the pause counter cleared.
  - FA / AA -> ack_tick / bat_tick; stay in IDLE.
  - 00 / FF / FC -> err_tick; stay in IDLE.
  - Any other byte -> make event (ext=0, break=0); stay in IDLE.
- EXT: F0 -> EXT_BRK; any other byte -> make event (ext=1) -> IDLE.
- BRK: any byte -> break event (ext=0) -> IDLE.
- EXT_BRK: any byte -> break event (ext=1) -> IDLE.
- Prefix bytes inside BRK / EXT_BRK are not reinterpreted; they are reported as key codes.
- PAUSE: count 7 further bytes with a 3-bit counter, whatever their values. On the 7th, pulse pause_tick and go to IDLE. No key_valid events and no modifier updates during PAUSE.
- Modifier updates are applied on emitted events only:
  - Non-ext 0x12 and non-ext 0x59 set/clear the lshift/rshift bits on make/break.
  - Ext 0x12 and ext 0x59 (the print-screen fake shift) produce events but leave shift_state unchanged.
  - Non-ext 0x14 drives lctrl; ext 0x14 drives rctrl.
  - shift_state = lshift|rshift; ctrl_state = lctrl|rctrl.
  - Non-ext 0x58 make toggles caps_lock only if the caps_held bit is clear, then sets caps_held. Typematic repeats therefore do not toggle. A 0x58 break clears caps_held.
  - Modifier outputs update in the same cycle as the corresponding key_valid.
- Timeout:
  - The counter runs only in EXT, BRK, EXT_BRK and PAUSE, and is cleared on every rx_done_tick.
  - When it reaches TIMEOUT_CYCLES-1: FSM -> IDLE, err_tick pulses, and no key event is emitted.
  - If rx_done_tick arrives in the same cycle as expiry, the byte takes priority: it is processed normally and no err_tick is raised.
- Reset mid-sequence discards the partial sequence. caps_lock returns to 0.

Decomposition:
- Package ps2_pkg holds:
  - FSM state encoding.
  - Byte constants: PFX_EXT=E0, PFX_BRK=F0, PFX_PAUSE=E1, RSP_ACK=FA, RSP_BAT=AA, RSP_BATFAIL=FC, and codes 12, 59, 14, 58.
  - PAUSE_LEN=7.
- Sub-module ps2_modifier_tracker:
  - Inputs: key_valid, key_code, key_ext, key_break.
  - Outputs: shift_state, ctrl_state, caps_lock.
  - Keeps the decoder FSM free of modifier logic.

Test Plan:
- Bytes 1C, then F0 1C -> key_valid twice: code=1C ext=0 brk=0, then code=1C ext=0 brk=1; each strobe is one cycle after the corresponding tick.
- E0 75, then E0 F0 75 -> make then break events, both code=75 ext=1; no event on the prefix bytes.
- Bytes 12, 1C, F0 12 -> shift_state=1 at the 12 make event, still 1 at the 1C event, 0 at the break event. E0 12 alone -> event with ext=1 and shift_state stays 0.
- Bytes 58 58 58 F0 58 58 -> caps_lock goes 1, stays 1 through the repeats and the break, then goes 0 on the final make.
- E1 14 77 E1 F0 14 F0 77 -> exactly one pause_tick after the last byte; no key_valid; ctrl_state stays 0.
- Byte F0, then no bytes for TIMEOUT_CYCLES (set to 100 in the bench) -> err_tick, FSM in IDLE; next byte 1C -> make event brk=0. FA in IDLE -> ack_tick only. Assert reset (0) after E0 -> all outputs 0; 75 after release -> ext=0.

Source files
------------

// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ps2_pkg
// Purpose : Shared state encoding and PS/2 Set-2 byte constants.
// Rev     : 1.0
// ============================================================================
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXT     = 3'd1,
    ST_BRK     = 3'd2,
    ST_EXT_BRK = 3'd3,
    ST_PAUSE   = 3'd4
  } state_e;

  localparam logic [7:0] PFX_EXT     = 8'hE0;
  localparam logic [7:0] PFX_BRK     = 8'hF0;
  localparam logic [7:0] PFX_PAUSE   = 8'hE1;
  localparam logic [7:0] RSP_ACK     = 8'hFA;
  localparam logic [7:0] RSP_BAT     = 8'hAA;
  localparam logic [7:0] RSP_BATFAIL = 8'hFC;
  localparam logic [7:0] RSP_ERR_00  = 8'h00;
  localparam logic [7:0] RSP_ERR_FF  = 8'hFF;

  localparam logic [7:0] KEY_LSHIFT  = 8'h12;
  localparam logic [7:0] KEY_RSHIFT  = 8'h59;
  localparam logic [7:0] KEY_CTRL    = 8'h14;
  localparam logic [7:0] KEY_CAPS    = 8'h58;

  localparam logic [2:0] PAUSE_LEN   = 3'd7;

endpackage : ps2_pkg
`default_nettype wire

// File: rtl/ps2_modifier_tracker.sv
`default_nettype none
// ============================================================================
// Module  : ps2_modifier_tracker
// Purpose : Shift / ctrl / caps-lock state driven by decoded key events.
// Rev     : 1.0
// ============================================================================
module ps2_modifier_tracker
  import ps2_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  input  logic       key_ext,
  input  logic       key_break,
  output logic       shift_state,
  output logic       ctrl_state,
  output logic       caps_lock
);

  logic lshift_q, rshift_q, lctrl_q, rctrl_q, caps_q, caps_held_q;
  logic lshift_d, rshift_d, lctrl_d, rctrl_d, caps_d, caps_held_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      lctrl_q     <= 1'b0;
      rctrl_q     <= 1'b0;
      caps_q      <= 1'b0;
      caps_held_q <= 1'b0;
    end else begin
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
      lctrl_q     <= lctrl_d;
      rctrl_q     <= rctrl_d;
      caps_q      <= caps_d;
      caps_held_q <= caps_held_d;
    end
  end

  // Extended 12/59 are the print-screen fake shifts and must not touch shift.
  always_comb begin
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;
    lctrl_d     = lctrl_q;
    rctrl_d     = rctrl_q;
    caps_d      = caps_q;
    caps_held_d = caps_held_q;
    if (key_valid) begin
      if (!key_ext) begin
        case (key_code)
          KEY_LSHIFT: lshift_d = !key_break;
          KEY_RSHIFT: rshift_d = !key_break;
          KEY_CTRL:   lctrl_d  = !key_break;
          KEY_CAPS: begin
            if (key_break) begin
              caps_held_d = 1'b0;
            end else begin
              if (!caps_held_q) caps_d = !caps_q;
              caps_held_d = 1'b1;
            end
          end
          default: ;
        endcase
      end else if (key_code == KEY_CTRL) begin
        rctrl_d = !key_break;
      end
    end
  end

  assign shift_state = lshift_q | rshift_q;
  assign ctrl_state  = lctrl_q | rctrl_q;
  assign caps_lock   = caps_q;

endmodule : ps2_modifier_tracker
`default_nettype wire

// File: rtl/ps2_scancode_decoder.sv
`default_nettype none
// ============================================================================
// Module  : ps2_scancode_decoder
// Purpose : PS/2 Set-2 byte stream to key events, pause and response strobes.
// Rev     : 1.0
// ============================================================================
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2_000_000,
  parameter int TO_W           = 21
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_done_tick,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       pause_tick,
  output logic       ack_tick,
  output logic       bat_tick,
  output logic       err_tick,
  output logic       shift_state,
  output logic       ctrl_state,
  output logic       caps_lock
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_e          state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [2:0]      pcnt_q, pcnt_d;
  logic            valid_q, valid_d, ext_q, ext_d, brk_q, brk_d;
  logic [7:0]      code_q, code_d;
  logic            pause_q, pause_d, ack_q, ack_d, bat_q, bat_d, err_q, err_d;
  logic            timeout;

  // A byte arriving in the expiry cycle wins over the timeout.
  assign timeout = (state_q != ST_IDLE) && !rx_done_tick && (to_cnt_q == TO_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      to_cnt_q <= '0;
      pcnt_q   <= '0;
      valid_q  <= 1'b0;
      code_q   <= '0;
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      pause_q  <= 1'b0;
      ack_q    <= 1'b0;
      bat_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
      pcnt_q   <= pcnt_d;
      valid_q  <= valid_d;
      code_q   <= code_d;
      ext_q    <= ext_d;
      brk_q    <= brk_d;
      pause_q  <= pause_d;
      ack_q    <= ack_d;
      bat_q    <= bat_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pcnt_d   = pcnt_q;
    to_cnt_d = '0;
    if (rx_done_tick) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_data == PFX_EXT) begin
            state_d = ST_EXT;
          end else if (rx_data == PFX_BRK) begin
            state_d = ST_BRK;
          end else if (rx_data == PFX_PAUSE) begin
            state_d = ST_PAUSE;
            pcnt_d  = '0;
          end
        end
        ST_EXT:     state_d = (rx_data == PFX_BRK) ? ST_EXT_BRK : ST_IDLE;
        ST_BRK:     state_d = ST_IDLE;
        ST_EXT_BRK: state_d = ST_IDLE;
        ST_PAUSE: begin
          if (pcnt_q == PAUSE_LEN - 3'd1) state_d = ST_IDLE;
          pcnt_d = pcnt_q + 3'd1;
        end
        default:    state_d = ST_IDLE;
      endcase
    end else if (timeout) begin
      state_d = ST_IDLE;
    end else if (state_q != ST_IDLE) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  always_comb begin
    valid_d = 1'b0;
    code_d  = code_q;
    ext_d   = ext_q;
    brk_d   = brk_q;
    pause_d = 1'b0;
    ack_d   = 1'b0;
    bat_d   = 1'b0;
    err_d   = 1'b0;
    if (rx_done_tick) begin
      case (state_q)
        ST_IDLE: begin
          case (rx_data)
            PFX_EXT, PFX_BRK, PFX_PAUSE: ;
            RSP_ACK: ack_d = 1'b1;
            RSP_BAT: bat_d = 1'b1;
            RSP_ERR_00, RSP_ERR_FF, RSP_BATFAIL: err_d = 1'b1;
            default: begin
              valid_d = 1'b1;
              code_d  = rx_data;
              ext_d   = 1'b0;
              brk_d   = 1'b0;
            end
          endcase
        end
        ST_EXT: begin
          if (rx_data != PFX_BRK) begin
            valid_d = 1'b1;
            code_d  = rx_data;
            ext_d   = 1'b1;
            brk_d   = 1'b0;
          end
        end
        ST_BRK, ST_EXT_BRK: begin
          valid_d = 1'b1;
          code_d  = rx_data;
          ext_d   = (state_q == ST_EXT_BRK);
          brk_d   = 1'b1;
        end
        ST_PAUSE: pause_d = (pcnt_q == PAUSE_LEN - 3'd1);
        default: ;
      endcase
    end else if (timeout) begin
      err_d = 1'b1;
    end
  end

  // Fed from the next-state event so modifiers change with key_valid.
  ps2_modifier_tracker u_mod (
    .clk         (clk),
    .reset       (reset),
    .key_valid   (valid_d),
    .key_code    (code_d),
    .key_ext     (ext_d),
    .key_break   (brk_d),
    .shift_state (shift_state),
    .ctrl_state  (ctrl_state),
    .caps_lock   (caps_lock)
  );

  assign key_valid  = valid_q;
  assign key_code   = code_q;
  assign key_ext    = ext_q;
  assign key_break  = brk_q;
  assign pause_tick = pause_q;
  assign ack_tick   = ack_q;
  assign bat_tick   = bat_q;
  assign err_tick   = err_q;

endmodule : ps2_scancode_decoder
`default_nettype wire
